// File: rtl/alu_pipe.sv
// Handshaked, width-parametrised ALU with a registered result/flag slot and a
// multi-cycle shift-add multiplier that stalls the input channel while it runs.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_PASA = 4'b1011;
  localparam logic [3:0] OP_PASB = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic [WIDTH-1:0] mul_sum_s;
  logic             accept_s;

  // Flag vector {V, C, N, Z} for a finished result.
  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res, input logic c, input logic v);
    return {v, c, res[WIDTH-1], (res == {WIDTH{1'b0}})};
  endfunction

  assign in_ready  = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;

  // Single-cycle datapath; SUB reuses the adder as a + ~b + 1 so C means "no borrow".
  always_comb begin
    shamt_s = b[SHW-1:0];
    b_eff_s = (opcode == OP_SUB) ? ~b : b;
    sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, (opcode == OP_SUB)};
    alu_y_s = {WIDTH{1'b0}};
    alu_c_s = 1'b0;
    alu_v_s = 1'b0;
    case (opcode)
      OP_AND:  alu_y_s = a & b;
      OP_OR:   alu_y_s = a | b;
      OP_ADD, OP_SUB: begin
        alu_y_s = sum_s[WIDTH-1:0];
        alu_c_s = sum_s[WIDTH];
        alu_v_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  alu_y_s = a ^ b;
      OP_NOR:  alu_y_s = ~(a | b);
      OP_SLL:  alu_y_s = a << shamt_s;
      OP_SRL:  alu_y_s = a >> shamt_s;
      OP_SRA:  alu_y_s = $signed(a) >>> shamt_s;
      OP_SLT:  alu_y_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_y_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASA: alu_y_s = a;
      OP_PASB: alu_y_s = b;
      default: alu_y_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state logic for the FSM, multiplier registers and output slot.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    flags_d     = flags_q;
    mul_sum_s   = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (opcode == OP_MUL)) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = {SHW{1'b0}};
          state_d  = ST_MUL;
        end else if (accept_s) begin
          y_d         = alu_y_s;
          flags_d     = mk_flags(alu_y_s, alu_c_s, alu_v_s);
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = mul_sum_s;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        // The last iteration's sum goes straight to the output slot.
        if (cnt_q == LAST_ITER) begin
          y_d         = mul_sum_s;
          flags_d     = mk_flags(mul_sum_s, 1'b0, 1'b0);
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {WIDTH{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      cnt_q       <= {SHW{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic scored
// against an arithmetic reference model, at WIDTH=32 and WIDTH=8.
module tb_alu_pipe;

  localparam int W = 32;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                         OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_SRA = 4'd8, OP_SLT = 4'd9, OP_SLTU = 4'd10, OP_PASA = 4'd11,
                         OP_PASB = 4'd12, OP_MUL = 4'd13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, y;
  logic [3:0]    opcode, flags;
  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]    a8, b8, y8;
  logic [3:0]    opcode8, flags8;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_until = 0;
  logic rnd_rdy = 1'b0;

  typedef struct {
    longint unsigned y;
    logic [3:0]      f;
    int              rdy;
  } exp_t;
  exp_t exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .y(y), .flags(flags)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .opcode(opcode8), .out_valid(out_valid8), .out_ready(out_ready8), .y(y8), .flags(flags8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference ALU expressed as plain integer arithmetic on w-bit values.
  function automatic void ref_alu(input int w, input logic [3:0] op, input longint unsigned av,
                                  input longint unsigned bv, output longint unsigned yv,
                                  output logic [3:0] fv);
    longint unsigned mask;
    longint sa, sb, r, maxv, minv;
    int sh;
    logic c, v;
    mask = (64'd1 << w) - 64'd1;
    sa = (((av >> (w - 1)) & 64'd1) != 64'd0) ? longint'(av) - longint'(64'd1 << w) : longint'(av);
    sb = (((bv >> (w - 1)) & 64'd1) != 64'd0) ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -maxv - 1;
    sh = int'(bv & 64'(w - 1));
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND:  yv = av & bv;
      OP_OR:   yv = av | bv;
      OP_ADD:  begin yv = (av + bv) & mask; c = (av + bv) > mask; r = sa + sb; v = (r > maxv) || (r < minv); end
      OP_SUB:  begin yv = (av - bv) & mask; c = (av >= bv); r = sa - sb; v = (r > maxv) || (r < minv); end
      OP_XOR:  yv = av ^ bv;
      OP_NOR:  yv = ~(av | bv) & mask;
      OP_SLL:  yv = (av << sh) & mask;
      OP_SRL:  yv = av >> sh;
      OP_SRA:  yv = $unsigned(sa >>> sh) & mask;
      OP_SLT:  yv = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLTU: yv = (av < bv) ? 64'd1 : 64'd0;
      OP_PASA: yv = av;
      OP_PASB: yv = bv;
      OP_MUL:  yv = (av * bv) & mask;
      default: yv = 64'd0;
    endcase
    fv = {v, c, ((yv >> (w - 1)) & 64'd1) != 64'd0, yv == 64'd0};
  endfunction

  // Cycle-level scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    logic exp_v, exp_ir;
    longint unsigned ey;
    logic [3:0] ef;
    exp_t e;
    if (rst) begin
      check_eq("in_ready_in_reset", 64'(in_ready), 64'd0);
      exp_q.delete();
      busy_until = 0;
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
      check_eq("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v && out_valid) begin
        check_eq("y", 64'(y), exp_q[0].y);
        check_eq("flags", 64'(flags), 64'(exp_q[0].f));
      end
      exp_ir = (cyc >= busy_until) && (!exp_v || out_ready);
      check_eq("in_ready", 64'(in_ready), 64'(exp_ir));
      if (exp_v && out_ready) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        ref_alu(W, opcode, 64'(a), 64'(b), ey, ef);
        e.y = ey;
        e.f = ef;
        e.rdy = (opcode == OP_MUL) ? cyc + W + 1 : cyc + 1;
        if (opcode == OP_MUL) busy_until = cyc + W + 1;
        exp_q.push_back(e);
      end
    end
  end

  // Present one operation and hold it until the DUT takes it; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic got;
    int n;
    in_valid = 1'b1;
    opcode = op;
    a = av;
    b = bv;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!got) check_eq("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    logic got;
    int n;
    in_valid8 = 1'b1;
    opcode8 = op;
    a8 = av;
    b8 = bv;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready8;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) check_eq("send8_timeout", 64'd0, 64'd1);
    in_valid8 = 1'b0;
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    longint unsigned ey8;
    logic [3:0] ef8;
    int n;
    logic [3:0] b2b_ops[11];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = 4'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = 8'd0; b8 = 8'd0; opcode8 = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_y", 64'(y), 64'd0);
    check_eq("rst_flags", 64'(flags), 64'd0);
    check_eq("rst_out_valid8", 64'(out_valid8), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    check_eq("add_ovf_y", 64'(y), 64'h8000_0000);
    check_eq("add_ovf_flags", 64'(flags), 64'hA);
    @(posedge clk); #1;
    send(OP_SUB, 32'd5, 32'd5);
    @(negedge clk);
    check_eq("sub_zero_flags", 64'(flags), 64'h5);
    @(posedge clk); #1;

    b2b_ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_PASA, OP_PASB};
    for (int i = 0; i < 11; i++) send(b2b_ops[i], 32'd2, 32'h8C00_000C);
    send(OP_SRA, 32'h8000_0000, 32'd4);
    @(negedge clk);
    check_eq("sra_y", 64'(y), 64'hF800_0000);
    check_eq("sra_flags", 64'(flags), 64'h2);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check_eq("slt_y", 64'(y), 64'd1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check_eq("sltu_y", 64'(y), 64'd0);
    @(posedge clk); #1;

    send(OP_MUL, 32'd2, 32'h8C00_000C);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    check_eq("mul_stall_cycles", 64'(n), 64'd32);
    check_eq("mul_y", 64'(y), 64'h1800_0018);
    check_eq("mul_flags", 64'(flags), 64'h0);
    check_eq("mul_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (W + 1) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("mul_ones_y", 64'(y), 64'd1);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(OP_ADD, 32'h10, 32'h20);
    in_valid = 1'b1; opcode = OP_SUB; a = 32'd9; b = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_y_hold", 64'(y), 64'h30);
      check_eq("bp_flags_hold", 64'(flags), 64'h0);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_y", 64'(y), 64'd5);
    check_eq("bp_next_flags", 64'(flags), 64'h4);
    @(posedge clk); #1;

    send(OP_MUL, 32'd12345, 32'd678);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_y", 64'(y), 64'd0);
    check_eq("abort_flags", 64'(flags), 64'd0);
    check_eq("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    check_eq("post_abort_y", 64'(y), 64'd7);
    @(posedge clk); #1;

    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'(ra) : 32'($urandom);
      send(rop, ra, rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    #1;

    send8(OP_ADD, 8'hFF, 8'h01);
    @(negedge clk);
    check_eq("w8_add_y", 64'(y8), 64'h00);
    check_eq("w8_add_flags", 64'(flags8), 64'h5);
    send8(OP_SLL, 8'h01, 8'd7);
    @(negedge clk);
    check_eq("w8_sll_y", 64'(y8), 64'h80);
    check_eq("w8_sll_flags", 64'(flags8), 64'h2);
    send8(OP_SUB, 8'h80, 8'h01);
    ref_alu(8, OP_SUB, 64'h80, 64'h01, ey8, ef8);
    @(negedge clk);
    check_eq("w8_sub_y", 64'(y8), ey8);
    check_eq("w8_sub_flags", 64'(flags8), 64'(ef8));
    @(posedge clk); #1;
    send8(OP_MUL, 8'h0F, 8'h11);
    n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 50) begin n++; @(negedge clk); end
    check_eq("w8_mul_wait", 64'(n), 64'd8);
    check_eq("w8_mul_y", 64'(y8), 64'hFF);
    check_eq("w8_mul_flags", 64'(flags8), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
